// File: rtl/uart_pkg.sv
// uart_pkg: shared serial-port types, defaults and status-bit positions
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;
  localparam int CLK_PER_BIT_DEF = 96;
  localparam int ST_TX_READY = 0;
  localparam int ST_DATA_READY = 1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with separate occupancy counter
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  // a full FIFO still accepts a write when the same cycle frees a slot
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with start/stop validation feeding a FWFT FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd,
  input  logic          rd,
  input  logic          clr_err,
  output logic [7:0]    data,
  output logic          data_ready,
  output logic [CW-1:0] count,
  output logic          frame_err,
  output logic          overrun
);
  localparam int TW = $clog2(CLK_PER_BIT);
  rx_state_t st, st_n;
  logic s1, rxs;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic brk, brk_n, tick, stop_ok, fe_set, ov_set, full, empty;
  assign tick = tmr == '0;
  assign ov_set = stop_ok && full && !rd;
  assign data_ready = !empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {rxd, s1};
  always_comb begin
    st_n = st;
    tmr_n = tick ? tmr : tmr - 1'b1;
    idx_n = idx;
    sh_n = sh;
    brk_n = brk;
    stop_ok = 1'b0;
    fe_set = 1'b0;
    case (st)
      IDLE:
        if (brk) brk_n = !rxs;
        else if (!rxs) begin
          st_n = START;
          tmr_n = TW'(CLK_PER_BIT / 2 - 1);
        end
      START:
        if (tick) begin
          st_n = rxs ? IDLE : DATA;
          tmr_n = TW'(CLK_PER_BIT - 1);
          idx_n = '0;
        end
      DATA:
        if (tick) begin
          sh_n[idx] = rxs;
          tmr_n = TW'(CLK_PER_BIT - 1);
          idx_n = idx + 1'b1;
          st_n = idx == 3'd7 ? STOP : DATA;
        end
      STOP:
        if (tick) begin
          st_n = IDLE;
          stop_ok = rxs;
          fe_set = !rxs;
          brk_n = !rxs;
        end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      tmr <= '0;
      idx <= '0;
      sh <= '0;
      brk <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      st <= st_n;
      tmr <= tmr_n;
      idx <= idx_n;
      sh <= sh_n;
      brk <= brk_n;
      frame_err <= fe_set || (frame_err && !clr_err);
      overrun <= ov_set || (overrun && !clr_err);
    end
  sync_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(stop_ok),
    .wdata(sh),
    .pop(rd),
    .rdata(data),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Asynchronous-serial receiver for the USB serial line (`u_txd` at the board edge). It is the receive end of the 8N1 link that the CPU's memory-mapped serial port drives outward. It deserialises bytes, validates start and stop bits, and buffers them in a small first-word-fall-through FIFO. The memory-mapping logic reads the head byte and the status bits from it.

## Interface
Parameters:
- `CLK_PER_BIT`, 96: system clocks per bit. 11.0592 MHz / 115200 baud. Must be even and ≥ 8.
- `DEPTH`, 8: FIFO entries. Power of two.

Ports:
- `clk` input 1: system clock (clk11M).
- `rst` input 1: reset, asynchronous, active-low.
- `rxd` input 1: serial line, idle high, asynchronous to `clk`.
- `rd` input 1: single-cycle pop strobe, issued by the CPU load of the data address.
- `clr_err` input 1: clears `frame_err` and `overrun`.
- `data` output 8: FIFO head byte. Valid while `data_ready`=1.
- `data_ready` output 1: FIFO non-empty.
- `count` output $clog2(DEPTH+1): FIFO occupancy.
- `frame_err` output 1: sticky. Set when a stop bit is bad.
- `overrun` output 1: sticky. Set when a byte is dropped because the FIFO is full.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. Define `rxs` as the synchronized value.
- Receiver FSM states are IDLE, START, DATA and STOP. It uses a bit-timer `tmr` (counts down) and a bit index `idx` (0..7).
  - IDLE: when `rxs`=0, load `tmr`=CLK_PER_BIT/2−1 and go to START.
  - START: when `tmr`=0, sample `rxs`.
    - If 1 (glitch): go to IDLE.
    - Otherwise load `tmr`=CLK_PER_BIT−1, set `idx`=0 and go to DATA.
  - DATA: when `tmr`=0, shift `rxs` into bit `idx` of the shift register (LSB first) and reload `tmr`.
    - After `idx`=7, go to STOP.
  - STOP: when `tmr`=0, sample `rxs` and go to IDLE.
    - If 1 and the FIFO is not full: push the byte.
    - If 1 and the FIFO is full: set `overrun`; the byte is lost.
    - If 0: set `frame_err` and discard the byte. IDLE then re-arms only after `rxs` has been seen high (break guard flag).
- FIFO:
  - `data` is always `mem[rd_ptr]`.
  - Pointers have log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is tracked separately.
  - Full means `count`=DEPTH.
- `rd` when `count`=0 is ignored. Pointers do not change and no error is raised.
- Push and `rd` in the same cycle:
  - When full: both take effect, `count` stays DEPTH, and there is no overrun.
  - When empty: only the push takes effect.
- `clr_err` in the same cycle as a new error event: the set wins.
- Reset state:
  - FSM in IDLE, break guard clear.
  - `count`=0, `data_ready`=0, `frame_err`=0, `overrun`=0.
  - `data`=0 (memory reset to 0).
- Reset deasserted mid-frame: the partial frame is lost. The receiver resynchronises on the next falling edge that follows high idle.

## Timing
- Let t0 be the first cycle in which the FSM is in IDLE and sees `rxs`=0. This is 2 to 3 cycles after the `rxd` edge.
- Start bit is sampled at t0+CLK_PER_BIT/2.
- Data bit i is sampled at t0+CLK_PER_BIT/2+(i+1)·CLK_PER_BIT.
- Stop bit is sampled at t0+CLK_PER_BIT/2+9·CLK_PER_BIT.
- The push is registered at that edge. `data_ready`, `data` and `count` update in the following cycle. For the defaults that is t0+913.
- `rd` at edge n: `data`/`count` show the next entry at n+1.
- Back-to-back frames with zero idle between the stop bit and the next start bit are received without loss.
- All outputs are registered. There is no combinational path from `rxd` or `rd` to any output.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Default `CLK_PER_BIT` (96).
  - Status-bit positions used by memory mapping: bit0 = tx ready, bit1 = `data_ready`.
- One sub-module `sync_fifo`, parameterised by width (8) and DEPTH.
  - Ports: push/wdata, pop/rdata, count, full, empty.
  - Reusable for the future transmit queue.
- The top holds the synchronizer, FSM, timers and error flags.

## Test plan
- Reset then idle high for 200 cycles -> `data_ready`=0, `count`=0, no error flags.
- Send 0xA5 at 115200 baud, then pulse `rd` once -> `data_ready`=1 at t0+913 with `data`=0xA5 and `count`=1. After `rd`: `count`=0, `data_ready`=0.
- Send 0x00, 0xFF, 0x3C back-to-back with no idle, then 3 reads -> `count` reaches 3. Reads return 0x00, 0xFF, 0x3C in order.
- Send 9 bytes 0x01..0x09 without reading -> `count`=8 and `overrun`=1. Reads return 0x01..0x08. `clr_err` clears `overrun`.
- Send 0x55 with the stop bit held low for 3 bit times, then 0x66 after idle -> `frame_err`=1 and 0x55 is not stored. 0x66 is received and stored normally.
- Low glitch of 20 cycles on `rxd`, then assert `rst` during DATA of the following frame -> no byte is stored from either event. The next clean 0x7E is received correctly.
